regfile_access_ctrl: RTL

Controller owning the register file's write port and one read port. Merges write-back stage writes with debug-unit register writes (write-back always has priority). Runs a register-dump sequencer that streams all registers to the debug unit over a valid/ready handshake while the pipeline is halted. Sits between the write-back stage, the debug unit and the register file.

---
 rtl/regfile_access_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// Register file access controller: merges write-back and debug writes onto the
// single write port and streams every register to the debug unit while halted.
module regfile_access_ctrl #(
  parameter int NB_DATA           = 32,
  parameter int N_REGISTERS       = 32,
  parameter int NB_ADDR_REGISTERS = $clog2(N_REGISTERS)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_wb_w_en,
  input  logic [NB_ADDR_REGISTERS-1:0] i_wb_reg_num,
  input  logic [NB_DATA-1:0]           i_wb_w_data,
  input  logic                         i_dbg_w_req,
  input  logic [NB_ADDR_REGISTERS-1:0] i_dbg_reg_num,
  input  logic [NB_DATA-1:0]           i_dbg_w_data,
  output logic                         o_dbg_w_ack,
  input  logic                         i_halted,
  input  logic                         i_dump_start,
  input  logic                         i_dump_ready,
  output logic                         o_dump_valid,
  output logic [NB_DATA-1:0]           o_dump_data,
  output logic [NB_ADDR_REGISTERS-1:0] o_dump_idx,
  output logic                         o_dump_last,
  output logic                         o_dump_done,
  output logic                         o_busy,
  output logic                         o_rf_w_en,
  output logic [NB_ADDR_REGISTERS-1:0] o_rf_w_num,
  output logic [NB_DATA-1:0]           o_rf_w_data,
  output logic [NB_ADDR_REGISTERS-1:0] o_rf_r_num,
  input  logic [NB_DATA-1:0]           i_rf_r_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} state_t;

  localparam logic [NB_ADDR_REGISTERS-1:0] LAST_IDX = NB_ADDR_REGISTERS'(N_REGISTERS - 1);

  state_t                         r_state;
  logic [NB_ADDR_REGISTERS-1:0]   r_idx;
  logic                           r_dump_valid;
  logic [NB_DATA-1:0]             r_dump_data;
  logic [NB_ADDR_REGISTERS-1:0]   r_dump_idx;
  logic                           r_dump_done;

  logic                           w_dbg_sel;
  logic                           w_wr_en;
  logic [NB_ADDR_REGISTERS-1:0]   w_wr_num;
  logic [NB_DATA-1:0]             w_wr_data;

  // Write-back always wins; debug only gets the port when no dump is running.
  always_comb begin
    w_dbg_sel = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_num  = i_wb_reg_num;
    w_wr_data = i_wb_w_data;
    if (i_wb_w_en) begin
      w_wr_en = 1'b1;
    end else if (i_dbg_w_req && (r_state == ST_IDLE)) begin
      w_dbg_sel = 1'b1;
      w_wr_en   = 1'b1;
      w_wr_num  = i_dbg_reg_num;
      w_wr_data = i_dbg_w_data;
    end
  end

  assign o_rf_w_en   = w_wr_en && (w_wr_num != '0);
  assign o_rf_w_num  = w_wr_num;
  assign o_rf_w_data = w_wr_data;
  assign o_dbg_w_ack = w_dbg_sel;

  assign o_rf_r_num   = (r_state == ST_IDLE) ? '0 : r_idx;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_dump_valid = r_dump_valid;
  assign o_dump_data  = r_dump_data;
  assign o_dump_idx   = r_dump_idx;
  assign o_dump_last  = r_dump_valid && (r_dump_idx == LAST_IDX);
  assign o_dump_done  = r_dump_done;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_dump_valid <= 1'b0;
      r_dump_data  <= '0;
      r_dump_idx   <= '0;
      r_dump_done  <= 1'b0;
    end else begin
      r_dump_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_dump_start && i_halted) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
          end
        end
        ST_LOAD: begin
          if (!i_halted) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_dump_valid <= 1'b0;
          end else begin
            r_dump_data  <= i_rf_r_data;
            r_dump_idx   <= r_idx;
            r_dump_valid <= 1'b1;
            r_state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          // Losing halt takes precedence over a same-cycle handshake.
          if (!i_halted) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_dump_valid <= 1'b0;
          end else if (i_dump_ready) begin
            r_dump_valid <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_state     <= ST_IDLE;
              r_idx       <= '0;
              r_dump_done <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_LOAD;
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_idx        <= '0;
          r_dump_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
